// File: rtl/hpm_counter_bank.sv
// Machine counter bank: mcycle, minstret, NUM_HPM event counters with selectors, and mcountinhibit.
// CSR reads are registered (1-cycle latency); writes take effect at the next clock edge.
module hpm_counter_bank #(
   parameter int NUM_HPM    = 4,
   parameter int CNT_WIDTH  = 64,
   parameter int NUM_EVENTS = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [11:0]           csr_addr_i,
   input  logic                  csr_re_i,
   input  logic                  csr_we_i,
   input  logic [31:0]           csr_wdata_i,
   output logic [31:0]           csr_rdata_o,
   output logic                  csr_rvalid_o,
   output logic                  csr_hit_o,
   input  logic                  instret_i,
   input  logic [NUM_EVENTS-1:0] event_i,
   output logic [NUM_HPM+1:0]    ovf_o
);

   localparam int NCNT = NUM_HPM + 2;
   localparam int EW   = $clog2(NUM_EVENTS + 1);
   localparam int NEVT = (NUM_HPM > 0) ? NUM_HPM : 1;

   // Counter slot i maps to CSR index 0 (mcycle), 2 (minstret), then 3, 4, ...
   function automatic logic [4:0] cnt_idx(input int i);
      if (i == 0)      return 5'd0;
      else if (i == 1) return 5'd2;
      else             return 5'(i + 1);
   endfunction

   function automatic logic [31:0] inh_mask_f();
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < NCNT; i++) m[cnt_idx(i)] = 1'b1;
      return m;
   endfunction

   localparam logic [31:0] INH_MASK = inh_mask_f();

   logic [CNT_WIDTH-1:0] cnt_q [NCNT];
   logic [CNT_WIDTH-1:0] cnt_d [NCNT];
   logic [EW-1:0]        evt_q [NEVT];
   logic [EW-1:0]        evt_d [NEVT];
   logic [31:0]          inh_q, inh_d;
   logic [NCNT-1:0]      ovf_q, ovf_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 rvalid_q;

   logic [6:0]           addr_blk;
   logic [4:0]           idx;
   logic                 is_lo, is_hi, is_inh, is_evt;
   logic [NUM_EVENTS:0]  ev_ext;
   logic [NCNT-1:0]      inc, inc_en, wr_lo, wr_hi;
   logic [31:0]          rd_val;
   logic [63:0]          cnt_ext;

   always_comb begin
      addr_blk  = csr_addr_i[11:5];
      idx       = csr_addr_i[4:0];
      is_lo     = (addr_blk == 7'h58) && (idx != 5'd1);
      is_hi     = (addr_blk == 7'h5C) && (idx != 5'd1);
      is_inh    = (csr_addr_i == 12'h320);
      is_evt    = (addr_blk == 7'h19) && (idx >= 5'd3);
      csr_hit_o = is_lo | is_hi | is_inh | is_evt;
   end

   // Selector value 0 picks the constant-zero bit, so it never counts.
   always_comb begin
      ev_ext = {event_i, 1'b0};
      inc    = '0;
      inc[0] = 1'b1;
      inc[1] = instret_i;
      for (int k = 0; k < NUM_HPM; k++) inc[k+2] = ev_ext[evt_q[k]];
      for (int i = 0; i < NCNT; i++) inc_en[i] = inc[i] & ~inh_q[cnt_idx(i)];
   end

   // A write to either half wins over the increment for that counter.
   always_comb begin
      for (int i = 0; i < NCNT; i++) begin
         wr_lo[i] = csr_we_i && is_lo && (idx == cnt_idx(i));
         wr_hi[i] = csr_we_i && is_hi && (idx == cnt_idx(i));
         cnt_d[i] = cnt_q[i];
         ovf_d[i] = 1'b0;
         if (wr_lo[i]) begin
            cnt_d[i][31:0] = csr_wdata_i;
         end else if (wr_hi[i]) begin
            cnt_d[i][CNT_WIDTH-1:32] = csr_wdata_i[CNT_WIDTH-33:0];
         end else if (inc_en[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            ovf_d[i] = &cnt_q[i];
         end
      end
   end

   always_comb begin
      inh_d   = inh_q;
      rd_val  = '0;
      cnt_ext = '0;
      for (int k = 0; k < NEVT; k++) evt_d[k] = evt_q[k];
      if (is_inh) begin
         rd_val = inh_q;
         if (csr_we_i) inh_d = csr_wdata_i & INH_MASK;
      end
      for (int k = 0; k < NUM_HPM; k++) begin
         if (is_evt && (idx == 5'(k + 3))) begin
            rd_val = 32'(evt_q[k]);
            if (csr_we_i) begin
               if (csr_wdata_i <= 32'(NUM_EVENTS)) evt_d[k] = csr_wdata_i[EW-1:0];
               else                                evt_d[k] = '0;
            end
         end
      end
      for (int i = 0; i < NCNT; i++) begin
         if ((is_lo || is_hi) && (idx == cnt_idx(i))) begin
            cnt_ext = 64'(cnt_q[i]);
            rd_val  = is_lo ? cnt_ext[31:0] : cnt_ext[63:32];
         end
      end
      rdata_d = csr_re_i ? rd_val : rdata_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
         for (int k = 0; k < NEVT; k++) evt_q[k] <= '0;
         inh_q    <= '0;
         ovf_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
         for (int k = 0; k < NEVT; k++) evt_q[k] <= evt_d[k];
         inh_q    <= inh_d;
         ovf_q    <= ovf_d;
         rdata_q  <= rdata_d;
         rvalid_q <= csr_re_i;
      end
   end

   assign csr_rdata_o  = rdata_q;
   assign csr_rvalid_o = rvalid_q;
   assign ovf_o        = ovf_q;

endmodule

// File: doc/hpm_counter_bank.md
# hpm_counter_bank

Parametrised machine counter bank for the RV32 core: implements mcycle, minstret, a configurable number of mhpmcounterN/mhpmcounterNh pairs with mhpmeventN selectors, and mcountinhibit. It sits beside the CSR file in the execute stage. The CSR file forwards any access in the counter address ranges (0xB00–0xB9F, 0x320–0x33F) here and muxes back the registered read data.

## Interface
- NUM_HPM, 4, implemented HPM counters, range 0..29; counters 3..NUM_HPM+2 exist.
- CNT_WIDTH, 64, counter width, range 33..64; bits above CNT_WIDTH read 0.
- NUM_EVENTS, 8, number of event inputs, range 1..31.
- clk_i  in  1  core clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- csr_addr_i  in  12  CSR address (csr package encoding; mcountinhibit = 0x320).
- csr_re_i  in  1  read strobe.
- csr_we_i  in  1  write strobe; single-cycle, full 32-bit write (CSR file resolves set/clear).
- csr_wdata_i  in  32  write data.
- csr_rdata_o  out  32  read data, valid one cycle after csr_re_i.
- csr_rvalid_o  out  1  read-data valid pulse.
- csr_hit_o  out  1  combinational: address is in this bank's map.
- instret_i  in  1  one instruction retired this cycle.
- event_i  in  NUM_EVENTS  per-cycle event pulses.
- ovf_o  out  NUM_HPM+2  one-cycle pulse when a counter wraps (bit 0 mcycle, bit 1 minstret, bit k+2 counter k+3).

## Operation
- Reset: all counters, mhpmevent and mcountinhibit registers = 0; csr_rdata_o = 0, csr_rvalid_o = 0, ovf_o = 0.
- mcycle: +1 every cycle unless mcountinhibit[0].
- minstret: +1 when instret_i and not mcountinhibit[2].
- HPM counter N: +1 when mhpmeventN = e, with 1 ≤ e ≤ NUM_EVENTS, event_i[e-1] = 1 and mcountinhibit[N] = 0. e = 0 means never count.
- mhpmeventN is WARL. A write of a value > NUM_EVENTS stores 0.
- mcountinhibit is WARL. Only bits 0, 2 and 3..NUM_HPM+2 are writable; all other bits read 0.
- Low-half write (0xB00+N) replaces bits [31:0]. High-half write (0xB80+N) replaces bits [CNT_WIDTH-1:32]; excess write bits are dropped.
- Write vs increment in the same cycle on the same counter: the written value is stored and the increment is discarded. An increment on the other half's carry is also discarded.
- Wrap: at 2^CNT_WIDTH-1 an increment yields 0 and pulses the matching ovf_o bit for one cycle. A CSR write never pulses ovf_o.
- Unimplemented HPM indices (N > NUM_HPM+2 within the ranges):
  - csr_hit_o = 1.
  - Reads return 0; writes are ignored.
- Addresses 0xB01 and 0xB81 (unused slots): csr_hit_o = 0.
- Read: csr_rdata_o is sampled from the pre-update counter value of the csr_re_i cycle.
- Read and write to the same address in one cycle: the read returns the old value.

## Timing
- csr_hit_o: combinational from csr_addr_i.
- Read latency: 1 cycle. csr_rvalid_o is high exactly the cycle after csr_re_i; back-to-back reads are allowed every cycle.
- Write latency: the new value is visible to a read issued the next cycle. Counting resumes from the written value on the cycle after the write.
- mcountinhibit write at cycle t: the increment at cycle t uses the old inhibit; cycle t+1 uses the new value.
- Increment path is a single-cycle CNT_WIDTH adder per counter; no multi-cycle carry.
- Reset asserted mid-operation: all state clears immediately (asynchronous). No pending read valid survives reset.

## Test plan
- Reset release, 10 idle cycles, read 0xB00 → csr_rvalid_o one cycle after csr_re_i, csr_rdata_o = value of mcycle at the read cycle (10 ± read offset). Read 0xB80 → 0.
- Write 0xB00 = 0xFFFF_FFFE and 0xB80 = 0xFFFF_FFFF (CNT_WIDTH=64), then 2 cycles → ovf_o[0] pulses once, mcycle = 0 → 1 the cycle after. Write 0x320 = 0x1 → mcycle frozen over 5 cycles.
- Write 0x323 = 2, pulse event_i[1] 7 times and event_i[0] 3 times → mhpmcounter3 = 7. Write 0x323 = 40 with NUM_EVENTS=8 → reads back 0, counting stops.
- Write to 0xB02 = 0x100 in the same cycle as instret_i = 1 → minstret reads 0x100, not 0x101.
- NUM_HPM=4: write 0xB10 = 0x55 → csr_hit_o = 1, read returns 0. Access 0xB01 → csr_hit_o = 0.
- Assert rst_ni low for 1 cycle mid-count with csr_re_i pending → all counters read 0, csr_rvalid_o = 0 the following cycle.
